gb_instr_issuer: RTL and testbench
==================================

// Module: gb_instr_issuer
// PURPOSE
// Hardware stimulus engine for gbprocessor: the driving end of its instruction/valid/probe interface.
// Buffers 8-bit opcodes from a host and issues each one as a single-cycle valid pulse.
// Samples probe a fixed delay after each pulse and returns {opcode, probe} on a ready/valid result port.
// Sits between the host/test logic and the gbprocessor instruction/valid/probe ports.
// PARAMETERS
// DEPTH        8   instruction buffer entries; power of 2, >=2
// PROBE_DELAY  4   cycles from valid-high cycle to probe sample; >=1
// CNT_W        16  width of issued_count; wraps modulo 2^CNT_W
// PORTS
// clock          in   1      system clock, rising edge
// reset          in   1      synchronous, active-high
// in_data        in   8      opcode from host
// in_valid       in   1      host offers in_data
// in_ready       out  1      buffer can accept; equals (count < DEPTH), registered count
// instruction    out  8      opcode to gbprocessor
// valid          out  1      one-cycle issue strobe to gbprocessor
// probe          in   8      gbprocessor probe output
// res_data       out  16     {issued opcode[15:8], sampled probe[7:0]}
// res_valid      out  1      result available
// res_ready      in   1      consumer accepts result
// busy           out  1      high whenever state != IDLE or count != 0
// issued_count   out  CNT_W  number of valid pulses since reset
// BEHAVIOUR
// Reset: valid=0, instruction=8'h00, res_valid=0, res_data=0, issued_count=0, FIFO flushed, state=IDLE.
// Reset values appear after the first clock edge with reset high.
// Reset mid-operation aborts any WAIT/REPORT. The pending result is dropped and buffered opcodes are discarded.
// Push: a word is accepted on every edge where in_valid && in_ready. in_ready=0 when full, even if a pop occurs in the same cycle.
// FSM:
//  IDLE   -> ISSUE when count != 0.
//  ISSUE  -> valid=1 for exactly this cycle; instruction=FIFO head; head popped; issued_count++.
//            Then WAIT with the delay counter loaded to PROBE_DELAY.
//  WAIT   -> stays PROBE_DELAY cycles; counter decrements each cycle.
//            On the last WAIT cycle probe is registered into res_data[7:0] and the opcode into res_data[15:8].
//            Then REPORT.
//  REPORT -> res_valid=1; res_data stable until the handshake res_valid && res_ready.
//            On handshake: ISSUE if count != 0 at that edge, else IDLE.
// Issue timing:
//  - Valid pulse at cycle c: WAIT occupies c+1..c+PROBE_DELAY; probe sampled in cycle c+PROBE_DELAY; res_valid from c+PROBE_DELAY+1.
//  - Push accepted at edge t into an empty FIFO with the engine in IDLE: valid high in cycle t+2.
//  - Back-to-back issue with res_ready=1: valid pulses are exactly PROBE_DELAY+2 cycles apart.
// Outputs: instruction holds the last issued opcode outside ISSUE; valid is 0 in all states except ISSUE.
// issued_count wraps 2^CNT_W-1 -> 0 without any flag.
// Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged; pushed data is preserved.
// ISSUE is entered only with count != 0, so a pop from an empty FIFO cannot occur.
// All outputs are registered; no combinational path from probe or res_ready to any output.
// STRUCTURE
// gb_pkg (shared):
//  - typedef logic [7:0] gb_instr_t and gb_probe_t
//  - typedef struct packed {gb_instr_t instr; gb_probe_t probe;} gb_result_t
//  - typedef enum {IDLE, ISSUE, WAIT, REPORT} gb_issue_state_t
// Sub-module gb_sync_fifo #(WIDTH, DEPTH): clock, reset, push, pop, wdata, rdata, count, full, empty.
//  - Reused by the bench-side checker.
// Top level: FSM, delay counter, result register, issued_count.
// TESTING
// Reset for 2 cycles -> valid=0, instruction=8'h00, res_valid=0, in_ready=1, busy=0, issued_count=0.
// Push 8'h80 at edge t, PROBE_DELAY=4, probe model returns 8'h3C ->
//  valid=1 only in cycle t+2 with instruction=8'h80; res_valid at t+7; res_data=16'h803C.
// Three pushes 8'h04, 8'h0C, 8'h80, res_ready=1 -> three valid pulses 6 cycles apart;
//  results return in order; issued_count=3.
// res_ready=0, in_valid held high with DEPTH=8 -> exactly 9 words accepted, then in_ready=0;
//  one valid pulse only; res_data stable for 20 cycles.
// Reset asserted in the second WAIT cycle -> res_valid never rises; count=0; issued_count=0;
//  next push issues normally at t+2.
// CNT_W=4, 17 instructions issued -> issued_count reads 4'h1 after the last pulse; no other side effect.

Source files
------------

// File: rtl/gb_instr_issuer_pkg.sv
// gb_pkg: shared types for the gbprocessor instruction issuer and its
// checker.
//   gb_instr_t       - 8-bit opcode driven onto the gbprocessor instruction port
//   gb_probe_t       - 8-bit value read back from the gbprocessor probe port
//   gb_result_t      - {issued opcode, sampled probe} returned to the host
//   gb_issue_state_t - issue engine states
package gb_pkg;

   typedef logic [7:0] gb_instr_t;
   typedef logic [7:0] gb_probe_t;

   typedef struct packed {
      gb_instr_t instr;
      gb_probe_t probe;
   } gb_result_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      REPORT
   } gb_issue_state_t;

endpackage

// File: rtl/gb_instr_issuer_fifo.sv
// gb_sync_fifo: single-clock FIFO with a combinational head read.
//   clock, reset : rising-edge clock, synchronous active-high reset (flush)
//   push, wdata  : write wdata when push and not full
//   pop          : drop the head entry when pop and not empty
//   rdata        : current head entry (valid when !empty)
//   count        : number of stored entries, 0..DEPTH
//   full, empty  : count == DEPTH / count == 0
// Push and pop in the same cycle leave count unchanged and keep both words.
module gb_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define contents.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gb_instr_issuer.sv
// gb_instr_issuer: buffers host opcodes and issues each to gbprocessor as a
// one-cycle valid strobe, samples probe PROBE_DELAY cycles later and returns
// {opcode, probe} on a ready/valid result port.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_data, in_valid   : host opcode offer
//   in_ready            : buffer has room (registered fifo count < DEPTH)
//   instruction, valid  : opcode and issue strobe to gbprocessor
//   probe               : gbprocessor probe output
//   res_data, res_valid : {opcode, probe} result, held until res_ready
//   res_ready           : result consumer accepts
//   busy                : engine not idle or opcodes still buffered
//   issued_count        : valid pulses since reset, wraps modulo 2^CNT_W
// Every output is a flop or a decode of flops; probe and res_ready only
// reach registers.
module gb_instr_issuer
   import gb_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned PROBE_DELAY = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       instruction,
   output logic             valid,
   input  logic [7:0]       probe,
   output logic [15:0]      res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic [CNT_W-1:0] issued_count
);

   localparam int unsigned DW = $clog2(PROBE_DELAY + 1);
   localparam logic [DW-1:0] DLY_LOAD = DW'(PROBE_DELAY);
   localparam logic [DW-1:0] DLY_LAST = DW'(1);

   gb_issue_state_t          state;
   gb_issue_state_t          next_state;
   logic [DW-1:0]            dly;
   gb_result_t               res_q;
   gb_instr_t                head;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     fifo_push;
   logic                     fifo_pop;

   assign fifo_push = in_valid && !fifo_full;
   // The head leaves the buffer on the edge that enters ISSUE; the same edge
   // latches it into the instruction register.
   assign fifo_pop  = (next_state == ISSUE);

   gb_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (in_data),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (fifo_count != '0) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (dly == DLY_LAST) next_state = REPORT;
         REPORT:  if (res_ready) next_state = (fifo_count != '0) ? ISSUE : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instruction  <= '0;
         issued_count <= '0;
         dly          <= '0;
         res_q        <= '0;
      end else begin
         if (next_state == ISSUE) begin
            instruction  <= head;
            issued_count <= issued_count + 1'b1;
         end
         if (state == ISSUE) begin
            dly <= DLY_LOAD;
         end else if (state == WAIT) begin
            dly <= dly - 1'b1;
         end
         if (state == WAIT && dly == DLY_LAST) begin
            res_q.instr <= instruction;
            res_q.probe <= probe;
         end
      end
   end

   assign valid     = (state == ISSUE);
   assign res_valid = (state == REPORT);
   assign res_data  = res_q;
   assign in_ready  = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Directed bench for gb_instr_issuer with a scoreboard of expected issued
// opcodes and results. The probe model returns instruction ^ 8'hBC only in
// the cycle PROBE_DELAY after a valid pulse, so mistimed sampling is visible.
module tb_gb_instr_issuer;
   import gb_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned PD    = 4;
   localparam int unsigned CW    = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    instruction;
   logic          valid;
   logic [7:0]    probe;
   logic [15:0]   res_data;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          busy;
   logic [CW-1:0] issued_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int age = 0;

   gb_instr_t   iq[$];
   logic [15:0] rq[$];
   int          pulse_cyc[$];

   always #5 clock = ~clock;

   gb_instr_issuer #(
      .DEPTH       (DEPTH),
      .PROBE_DELAY (PD),
      .CNT_W       (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instruction  (instruction),
      .valid        (valid),
      .probe        (probe),
      .res_data     (res_data),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .busy         (busy),
      .issued_count (issued_count)
   );

   // gbprocessor probe model
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (valid === 1'b1) age <= 1;
      else if (age != 0 && age < 64) age <= age + 1;
   end
   assign probe = (age == int'(PD)) ? (instruction ^ 8'hBC) : 8'hA5;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare each issue and each result handshake.
   always @(negedge clock) begin
      if (valid === 1'b1) begin
         pulse_cyc.push_back(cyc);
         if (iq.size() == 0) chk("issue_expected", 32'(iq.size() != 0), 32'd1);
         else chk("issue_op", 32'(instruction), 32'(iq.pop_front()));
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (rq.size() == 0) chk("result_expected", 32'(rq.size() != 0), 32'd1);
         else chk("result_data", 32'(res_data), 32'(rq.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
      iq.delete();
      rq.delete();
      pulse_cyc.delete();
   endtask

   task automatic expect_push(input gb_instr_t op);
      iq.push_back(op);
      rq.push_back({op, op ^ 8'hBC});
   endtask

   task automatic push(input gb_instr_t op);
      in_data  = op;
      in_valid = 1'b1;
      if (in_ready === 1'b1) expect_push(op);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_idle_in_time"}, 32'(busy === 1'b0), 32'd1);
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int k = 0;
      while (pulse_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int seen;
      int sent;
      int guard;

      // Reset state
      do_reset(2);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_instruction", 32'(instruction), 32'h00);
      chk("reset_res_valid", 32'(res_valid), 32'd0);
      chk("reset_res_data", 32'(res_data), 32'h0000);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_issued_count", 32'(issued_count), 32'd0);

      // Single opcode: push at edge t, valid in t+2, result from t+7
      res_ready = 1'b0;
      push(8'h80);
      chk("single_t1_valid", 32'(valid), 32'd0);
      chk("single_t1_busy", 32'(busy), 32'd1);
      tick();
      chk("single_t2_valid", 32'(valid), 32'd1);
      chk("single_t2_instruction", 32'(instruction), 32'h80);
      chk("single_t2_count", 32'(issued_count), 32'd1);
      tick();
      chk("single_t3_valid", 32'(valid), 32'd0);
      chk("single_t3_instruction_hold", 32'(instruction), 32'h80);
      repeat (3) tick();
      chk("single_t6_res_valid", 32'(res_valid), 32'd0);
      tick();
      chk("single_t7_res_valid", 32'(res_valid), 32'd1);
      chk("single_t7_res_data", 32'(res_data), 32'h803C);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("single_after_res_valid", 32'(res_valid), 32'd0);
      chk("single_after_busy", 32'(busy), 32'd0);
      chk("single_rq_drained", 32'(rq.size()), 32'd0);

      // Three back-to-back opcodes, consumer always ready
      do_reset(1);
      res_ready = 1'b1;
      push(8'h04);
      push(8'h0C);
      push(8'h80);
      wait_pulses(3, 60);
      wait_idle(30, "three");
      chk("three_pulses", 32'(pulse_cyc.size()), 32'd3);
      if (pulse_cyc.size() == 3) begin
         chk("three_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), PD + 2);
         chk("three_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), PD + 2);
      end
      chk("three_issued_count", 32'(issued_count), 32'd3);
      chk("three_rq_drained", 32'(rq.size()), 32'd0);

      // Buffer fill with the result held back
      do_reset(1);
      res_ready = 1'b0;
      acc = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         in_data = 8'(8'h10 + i);
         if (in_ready === 1'b1) begin
            acc++;
            expect_push(in_data);
         end
         tick();
      end
      in_valid = 1'b0;
      chk("full_accepted", 32'(acc), DEPTH + 1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_pulses", 32'(pulse_cyc.size()), 32'd1);
      chk("full_issued_count", 32'(issued_count), 32'd1);
      chk("full_res_valid", 32'(res_valid), 32'd1);
      for (int i = 0; i < 20; i++) begin
         chk("full_res_stable", 32'(res_data), 32'h10AC);
         tick();
      end

      // Reset during the second WAIT cycle
      do_reset(1);
      res_ready = 1'b1;
      push(8'h42);
      tick();
      chk("rst_wait_issue", 32'(valid), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      iq.delete();
      rq.delete();
      seen = 0;
      repeat (12) begin
         if (res_valid !== 1'b0) seen++;
         tick();
      end
      chk("rst_wait_no_result", 32'(seen), 32'd0);
      chk("rst_wait_busy", 32'(busy), 32'd0);
      chk("rst_wait_in_ready", 32'(in_ready), 32'd1);
      chk("rst_wait_issued_count", 32'(issued_count), 32'd0);
      chk("rst_wait_res_data", 32'(res_data), 32'h0000);
      push(8'h55);
      chk("rst_next_t1_valid", 32'(valid), 32'd0);
      tick();
      chk("rst_next_t2_valid", 32'(valid), 32'd1);
      chk("rst_next_t2_instruction", 32'(instruction), 32'h55);
      chk("rst_next_t2_count", 32'(issued_count), 32'd1);
      wait_idle(30, "rst_next");
      chk("rst_next_rq_drained", 32'(rq.size()), 32'd0);

      // 17 issues with a 4-bit issued_count
      do_reset(1);
      res_ready = 1'b1;
      sent = 0;
      guard = 0;
      while (sent < 17 && guard < 400) begin
         in_data  = 8'(sent * 7 + 1);
         in_valid = 1'b1;
         if (in_ready === 1'b1) begin
            expect_push(in_data);
            sent++;
         end
         tick();
         guard++;
      end
      in_valid = 1'b0;
      wait_pulses(17, 300);
      wait_idle(40, "wrap");
      chk("wrap_sent", 32'(sent), 32'd17);
      chk("wrap_pulses", 32'(pulse_cyc.size()), 32'd17);
      chk("wrap_issued_count", 32'(issued_count), 32'h1);
      chk("wrap_rq_drained", 32'(rq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
